// File: rtl/qif_synapse_driver.sv
// Synaptic current generator for the QIF neuron.
// Each TICK_PERIOD-cycle window latches which presynaptic inputs fired. The
// window's weights are then summed serially, one input per cycle. The sum is
// added to a leaky copy of the stored current and the result is saturated to
// signed 8 bits.
// TICK_PERIOD must be >= N_INPUTS + 2 so that the scan and apply phases finish
// before the next tick arrives.
module qif_synapse_driver #(
  parameter int N_INPUTS    = 4,
  parameter int DECAY_SHIFT = 3,
  parameter int TICK_PERIOD = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_INPUTS-1:0]         spike_in,
  input  logic                        wr_en,
  input  logic [$clog2(N_INPUTS)-1:0] wr_addr,
  input  logic signed [7:0]           wr_data,
  output logic signed [7:0]           I_syn,
  output logic                        syn_valid,
  output logic                        busy
);

  localparam int AddrW = $clog2(N_INPUTS);
  // The sum of N_INPUTS signed 8-bit weights always fits in this width.
  localparam int AccW  = 8 + AddrW + 1;
  // The width of the apply sum: current + leak + acc, with headroom.
  localparam int NextW = AccW + 2;
  localparam int CntW  = $clog2(TICK_PERIOD);

  localparam logic [AddrW-1:0]        LastIdx  = AddrW'(N_INPUTS - 1);
  localparam logic [CntW-1:0]         LastTick = CntW'(TICK_PERIOD - 1);
  localparam logic signed [NextW-1:0] SatMax   = NextW'(127);
  localparam logic signed [NextW-1:0] SatMin   = NextW'(-128);

  typedef enum logic [1:0] {StIdle, StScan, StApply} state_e;

  state_e                   state_q;
  logic [CntW-1:0]          tick_cnt_q;
  logic [N_INPUTS-1:0]      pending_q;
  logic [N_INPUTS-1:0]      snapshot_q;
  logic [AddrW-1:0]         idx_q;
  logic signed [AccW-1:0]   acc_q;
  logic signed [7:0]        i_syn_q;
  logic                     syn_valid_q;
  logic signed [7:0]        weight_q [N_INPUTS];

  logic                     tick;
  logic signed [AccW-1:0]   w_ext;
  logic signed [NextW-1:0]  cur_ext;
  logic signed [NextW-1:0]  acc_ext;
  logic signed [NextW-1:0]  next_full;
  logic signed [7:0]        next_sat;

  // Window boundary decode.
  assign tick = (tick_cnt_q == LastTick);

  // Free-running window counter. It restarts from zero when reset is released.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + CntW'(1);
    end
  end

  // Sticky per-input spike capture. Spikes that arrive on the tick cycle open the next window.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pending_q <= '0;
    end else if (tick && (state_q == StIdle)) begin
      pending_q <= spike_in;
    end else begin
      pending_q <= pending_q | spike_in;
    end
  end

  // Weight register file. Out-of-range addresses are dropped.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < N_INPUTS; i++) begin
        weight_q[i] <= '0;
      end
    end else if (wr_en && (int'(wr_addr) < N_INPUTS)) begin
      weight_q[wr_addr] <= wr_data;
    end
  end

  // Weight under scan, and the leak-plus-accumulate result with saturation.
  always_comb begin
    w_ext     = {{(AccW - 8){weight_q[idx_q][7]}}, weight_q[idx_q]};
    cur_ext   = {{(NextW - 8){i_syn_q[7]}}, i_syn_q};
    acc_ext   = {{(NextW - AccW){acc_q[AccW-1]}}, acc_q};
    // The arithmetic shift rounds toward -inf, so negative currents still leak toward zero.
    next_full = cur_ext - (cur_ext >>> DECAY_SHIFT) + acc_ext;
    if (next_full > SatMax) begin
      next_sat = 8'sh7f;
    end else if (next_full < SatMin) begin
      next_sat = 8'sh80;
    end else begin
      next_sat = next_full[7:0];
    end
  end

  // Control FSM: idle until tick, scan one input per cycle, then apply a single update.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q     <= StIdle;
      snapshot_q  <= '0;
      idx_q       <= '0;
      acc_q       <= '0;
      i_syn_q     <= '0;
      syn_valid_q <= 1'b0;
    end else begin
      syn_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (tick) begin
            snapshot_q <= pending_q;
            acc_q      <= '0;
            idx_q      <= '0;
            state_q    <= StScan;
          end
        end
        StScan: begin
          // A same-cycle weight write lands after this read, so the old weight is used.
          if (snapshot_q[idx_q]) begin
            acc_q <= acc_q + w_ext;
          end
          if (idx_q == LastIdx) begin
            state_q <= StApply;
          end else begin
            idx_q <= idx_q + AddrW'(1);
          end
        end
        StApply: begin
          i_syn_q     <= next_sat;
          syn_valid_q <= 1'b1;
          state_q     <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign I_syn     = i_syn_q;
  assign syn_valid = syn_valid_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: doc/qif_synapse_driver.md
Name: qif_synapse_driver

Overview:
Synaptic current generator that sits directly upstream of the QIF neuron. It sums weighted presynaptic spike events over fixed tick windows and applies leaky exponential decay to a stored current. It drives the neuron's signed 8-bit I_syn input, with saturation. Weights are runtime-loadable through a simple write port.

Parameters:
N_INPUTS, 4, number of presynaptic spike inputs (2..16)
DECAY_SHIFT, 3, leak factor: I - (I >>> DECAY_SHIFT) per tick
TICK_PERIOD, 8, clock cycles per integration window; must be >= N_INPUTS+2

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  reset, asynchronous, active-high
spike_in  input  N_INPUTS  presynaptic spike pulses, any width/duration
wr_en  input  1  weight write strobe
wr_addr  input  clog2(N_INPUTS)  weight index to write
wr_data  input  8  signed weight value
I_syn  output  8  signed synaptic current to the neuron (registered)
syn_valid  output  1  one-cycle pulse when I_syn has just been updated
busy  output  1  high while in SCAN or APPLY

Behaviour:
- Reset (rst_n=1, async): I_syn=0, syn_valid=0, busy=0, all weights=0, pending=0, snapshot=0, tick_cnt=0, acc=0, state=IDLE. Reset mid-scan aborts the window with no partial update.
- tick_cnt counts 0..TICK_PERIOD-1 and wraps. tick is asserted when tick_cnt==TICK_PERIOD-1; the first tick after reset release is in cycle TICK_PERIOD.
- Pending register is sticky per input: pending[i] is set on any cycle with spike_in[i]=1. Multiple pulses within one window count once.
- On tick (state IDLE):
  - snapshot <= pending.
  - pending <= spike_in of that same cycle. Spikes on the tick cycle therefore belong to the next window.
  - acc <= 0, idx <= 0, state -> SCAN.
- SCAN, one input per cycle for N_INPUTS cycles:
  - if snapshot[idx], acc <= acc + sign-extended weight[idx].
  - after idx==N_INPUTS-1, state -> APPLY.
- acc width: 8+clog2(N_INPUTS)+1 signed; it cannot overflow.
- APPLY, one cycle:
  - next = I_syn - (I_syn >>> DECAY_SHIFT) + acc, computed at full width with arithmetic shift (rounds toward -inf).
  - I_syn <= saturate(next, -128, +127); syn_valid <= 1; state -> IDLE.
- syn_valid is high for exactly one cycle: the cycle after APPLY.
- Latency: tick at cycle T; SCAN runs T+1..T+N_INPUTS; APPLY at T+N_INPUTS+1; new I_syn and syn_valid are visible at T+N_INPUTS+2. I_syn is held constant between updates.
- Empty window (snapshot=0): decay only. I_syn=0 stays 0. Negative I_syn decays toward 0: -1 -> 0, -8 -> -7.
- Weight writes:
  - accepted in any state; register semantics, visible the cycle after wr_en.
  - a write to weight[k] in the same cycle SCAN reads index k: SCAN uses the old value.
  - wr_addr >= N_INPUTS is ignored.
- busy = (state != IDLE).

Test Plan:
(Defaults N_INPUTS=4, DECAY_SHIFT=3, TICK_PERIOD=8 unless stated.)
1. Assert rst_n for 3 cycles, then release -> I_syn=0, syn_valid=0, busy=0. First tick at cycle 8; syn_valid pulses at cycle 14 with I_syn=0.
2. Write w0=40, then pulse spike_in[0] once -> update gives I_syn=40. Next three empty windows give 35, 31, 28, each with a single syn_valid pulse.
3. All weights=100, all inputs spike -> I_syn=127 (acc=400, saturated). All weights=-100 with all inputs spiking, repeated -> I_syn=-128 and it never wraps positive.
4. w1=10; spike_in[1] high only on the tick cycle -> the current update excludes it (I_syn unchanged by w1). The following update includes +10.
5. Five pulses on spike_in[2] with w2=7 inside one window -> I_syn increases by exactly 7. Also write w3=20 in the cycle SCAN reads idx 3 with spike pending -> old w3 is used; the new value applies next window.
6. Assert rst_n during SCAN (idx=2) -> outputs and weights are immediately 0 and busy=0; no syn_valid pulse. After release, normal tick timing restarts from tick_cnt=0.
